// File: rtl/uart_boot_loader.sv
// UART boot loader: parses an A5-framed program image from the UART receiver
// and streams 32-bit word writes into instruction memory while holding the CPU.
module uart_boot_loader #(
  parameter int ADDR_WIDTH   = 10,
  parameter int TIMEOUT_CLKS = 217000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Rx_DV_in,
  input  logic [7:0]            Rx_Byte_in,
  output logic                  Mem_WE_out,
  output logic [ADDR_WIDTH-1:0] Mem_Addr_out,
  output logic [31:0]           Mem_Data_out,
  output logic                  CPU_Hold_out,
  output logic                  Load_Done_out,
  output logic                  Err_out,
  output logic [1:0]            Err_Code_out
);

  localparam int              TW        = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0]   T_LAST    = TW'(TIMEOUT_CLKS - 1);
  localparam logic [16:0]     MAX_WORDS = 17'(2 ** ADDR_WIDTH);
  localparam logic [7:0]      SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t         state;
  logic [15:0]    word_cnt;
  logic [16:0]    word_idx;
  logic [1:0]     byte_idx;
  logic [31:0]    word_buf;
  logic [7:0]     csum;
  logic [TW-1:0]  tmo_cnt;

  // Word count and index compare as 17-bit values so N = 2^ADDR_WIDTH is legal
  logic [16:0]    len_next;
  logic [16:0]    word_idx_next;
  assign len_next      = {1'b0, Rx_Byte_in, word_cnt[7:0]};
  assign word_idx_next = word_idx + 17'd1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= S_IDLE;
      word_cnt      <= '0;
      word_idx      <= '0;
      byte_idx      <= '0;
      word_buf      <= '0;
      csum          <= '0;
      tmo_cnt       <= '0;
      Mem_WE_out    <= 1'b0;
      Mem_Addr_out  <= '0;
      Mem_Data_out  <= '0;
      CPU_Hold_out  <= 1'b0;
      Load_Done_out <= 1'b0;
      Err_out       <= 1'b0;
      Err_Code_out  <= 2'b00;
    end else begin
      Mem_WE_out    <= 1'b0;
      Load_Done_out <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Rx_DV_in && Rx_Byte_in == SYNC_BYTE) begin
            state        <= S_LEN_LO;
            CPU_Hold_out <= 1'b1;
            Err_out      <= 1'b0;
            Err_Code_out <= 2'b00;
            csum         <= '0;
            word_idx     <= '0;
            byte_idx     <= '0;
            word_buf     <= '0;
            tmo_cnt      <= '0;
          end
        end
        // Single-cycle result states; any byte arriving here is dropped
        S_DONE, S_ERROR: state <= S_IDLE;
        default: begin
          if (Rx_DV_in) begin
            tmo_cnt <= '0;
            case (state)
              S_LEN_LO: begin
                word_cnt[7:0] <= Rx_Byte_in;
                state         <= S_LEN_HI;
              end
              S_LEN_HI: begin
                word_cnt[15:8] <= Rx_Byte_in;
                if (len_next > MAX_WORDS) begin
                  state        <= S_ERROR;
                  Err_out      <= 1'b1;
                  Err_Code_out <= 2'b10;
                end else if (len_next == 17'd0) begin
                  state <= S_CHECK;
                end else begin
                  state <= S_DATA;
                end
              end
              S_DATA: begin
                csum <= csum ^ Rx_Byte_in;
                word_buf[{byte_idx, 3'b000} +: 8] <= Rx_Byte_in;
                byte_idx <= byte_idx + 2'd1;
                if (byte_idx == 2'd3) begin
                  Mem_WE_out   <= 1'b1;
                  Mem_Addr_out <= word_idx[ADDR_WIDTH-1:0];
                  Mem_Data_out <= {Rx_Byte_in, word_buf[23:0]};
                  word_idx     <= word_idx_next;
                  if (word_idx_next == {1'b0, word_cnt}) state <= S_CHECK;
                end
              end
              S_CHECK: begin
                if (Rx_Byte_in == csum) begin
                  state         <= S_DONE;
                  Load_Done_out <= 1'b1;
                  CPU_Hold_out  <= 1'b0;
                end else begin
                  state        <= S_ERROR;
                  Err_out      <= 1'b1;
                  Err_Code_out <= 2'b01;
                end
              end
              default: state <= S_IDLE;
            endcase
          end else if (tmo_cnt == T_LAST) begin
            // Partial word is discarded so a stale fragment never reaches memory
            state        <= S_ERROR;
            Err_out      <= 1'b1;
            Err_Code_out <= 2'b11;
            word_buf     <= '0;
            byte_idx     <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed self-checking bench for uart_boot_loader (ADDR_WIDTH=10, TIMEOUT_CLKS=1000).
module tb_uart_boot_loader;

  localparam int ADDR_WIDTH   = 10;
  localparam int TIMEOUT_CLKS = 1000;

  logic                  CLK = 1'b0;
  logic                  RST = 1'b1;
  logic                  Rx_DV_in = 1'b0;
  logic [7:0]            Rx_Byte_in = 8'h00;
  logic                  Mem_WE_out;
  logic [ADDR_WIDTH-1:0] Mem_Addr_out;
  logic [31:0]           Mem_Data_out;
  logic                  CPU_Hold_out;
  logic                  Load_Done_out;
  logic                  Err_out;
  logic [1:0]            Err_Code_out;

  int assertCount = 0;
  int failCount   = 0;
  int doneCount   = 0;
  int weStuck     = 0;
  logic prevWE    = 1'b0;
  logic [31:0] wrAddr[$];
  logic [31:0] wrData[$];

  uart_boot_loader #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .Rx_DV_in     (Rx_DV_in),
    .Rx_Byte_in   (Rx_Byte_in),
    .Mem_WE_out   (Mem_WE_out),
    .Mem_Addr_out (Mem_Addr_out),
    .Mem_Data_out (Mem_Data_out),
    .CPU_Hold_out (CPU_Hold_out),
    .Load_Done_out(Load_Done_out),
    .Err_out      (Err_out),
    .Err_Code_out (Err_Code_out)
  );

  always #5 CLK = ~CLK;

  // Record every memory write and done pulse, sampled mid-cycle
  always @(negedge CLK) begin
    if (Mem_WE_out) begin
      wrAddr.push_back(32'(Mem_Addr_out));
      wrData.push_back(Mem_Data_out);
      if (prevWE) weStuck++;
    end
    if (Load_Done_out) doneCount++;
    prevWE = Mem_WE_out;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge CLK);
    Rx_DV_in   = 1'b1;
    Rx_Byte_in = b;
  endtask

  task automatic endFrame();
    @(negedge CLK);
    Rx_DV_in   = 1'b0;
    Rx_Byte_in = 8'h00;
  endtask

  task automatic clearLog();
    wrAddr.delete();
    wrData.delete();
    doneCount = 0;
  endtask

  task automatic sendGoodFrame(input logic [7:0] csumByte);
    logic [7:0] frame [12];
    frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
              8'h93, 8'h00, 8'h10, 8'h00, csumByte};
    for (int i = 0; i < 12; i++) applyStimulus(frame[i]);
    endFrame();
  endtask

  task automatic checkTwoWrites(input string tag);
    checkOutput({tag, "_wrcount"}, 32'(wrAddr.size()), 32'd2);
    if (wrAddr.size() == 2) begin
      checkOutput({tag, "_addr0"}, wrAddr[0], 32'd0);
      checkOutput({tag, "_data0"}, wrData[0], 32'h0000_0013);
      checkOutput({tag, "_addr1"}, wrAddr[1], 32'd1);
      checkOutput({tag, "_data1"}, wrData[1], 32'h0010_0093);
    end
  endtask

  initial begin
    // Reset state
    #1;
    checkOutput("rst_we",   32'(Mem_WE_out), 32'd0);
    checkOutput("rst_addr", 32'(Mem_Addr_out), 32'd0);
    checkOutput("rst_data", Mem_Data_out, 32'd0);
    checkOutput("rst_hold", 32'(CPU_Hold_out), 32'd0);
    checkOutput("rst_done", 32'(Load_Done_out), 32'd0);
    checkOutput("rst_err",  32'(Err_out), 32'd0);
    checkOutput("rst_code", 32'(Err_Code_out), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // Good frame: checksum 13^93^10 = 90
    clearLog();
    sendGoodFrame(8'h90);
    checkOutput("good_done",  32'(Load_Done_out), 32'd1);
    checkOutput("good_hold",  32'(CPU_Hold_out), 32'd0);
    checkOutput("good_err",   32'(Err_out), 32'd0);
    @(negedge CLK);
    checkOutput("good_done_off", 32'(Load_Done_out), 32'd0);
    checkOutput("good_done_cnt", 32'(doneCount), 32'd1);
    checkTwoWrites("good");

    // Bad checksum
    clearLog();
    sendGoodFrame(8'h91);
    checkOutput("bad_err",  32'(Err_out), 32'd1);
    checkOutput("bad_code", 32'(Err_Code_out), 32'd1);
    checkOutput("bad_hold", 32'(CPU_Hold_out), 32'd1);
    @(negedge CLK);
    checkOutput("bad_err_sticky", 32'(Err_out), 32'd1);
    checkOutput("bad_done_cnt", 32'(doneCount), 32'd0);
    checkTwoWrites("bad");

    // Following good frame clears error at its A5
    clearLog();
    applyStimulus(8'hA5);
    endFrame();
    checkOutput("recov_err_clr",  32'(Err_out), 32'd0);
    checkOutput("recov_code_clr", 32'(Err_Code_out), 32'd0);
    checkOutput("recov_hold",     32'(CPU_Hold_out), 32'd1);
    applyStimulus(8'h01); applyStimulus(8'h00);
    applyStimulus(8'hEF); applyStimulus(8'hBE); applyStimulus(8'hAD); applyStimulus(8'hDE);
    applyStimulus(8'hEF ^ 8'hBE ^ 8'hAD ^ 8'hDE);
    endFrame();
    checkOutput("recov_done", 32'(Load_Done_out), 32'd1);
    checkOutput("recov_hold_off", 32'(CPU_Hold_out), 32'd0);
    checkOutput("recov_wrcount", 32'(wrAddr.size()), 32'd1);
    if (wrData.size() == 1) checkOutput("recov_data", wrData[0], 32'hDEAD_BEEF);

    // Length limit: N = 0x0401 rejected
    clearLog();
    applyStimulus(8'hA5); applyStimulus(8'h01); applyStimulus(8'h04);
    endFrame();
    checkOutput("len_err",  32'(Err_out), 32'd1);
    checkOutput("len_code", 32'(Err_Code_out), 32'd2);
    checkOutput("len_hold", 32'(CPU_Hold_out), 32'd1);
    repeat (3) @(negedge CLK);
    checkOutput("len_wrcount", 32'(wrAddr.size()), 32'd0);

    // N = 1024 accepted; word i carries value i, byte XOR over the image is 0
    clearLog();
    applyStimulus(8'hA5); applyStimulus(8'h00); applyStimulus(8'h04);
    for (int i = 0; i < 1024; i++) begin
      applyStimulus(i[7:0]);
      applyStimulus(i[15:8]);
      applyStimulus(8'h00);
      applyStimulus(8'h00);
    end
    applyStimulus(8'h00);
    endFrame();
    checkOutput("max_done", 32'(Load_Done_out), 32'd1);
    checkOutput("max_err",  32'(Err_out), 32'd0);
    checkOutput("max_wrcount", 32'(wrAddr.size()), 32'd1024);
    if (wrAddr.size() == 1024) begin
      checkOutput("max_mid_addr",  wrAddr[512], 32'h200);
      checkOutput("max_mid_data",  wrData[512], 32'h200);
      checkOutput("max_last_addr", wrAddr[1023], 32'h3FF);
      checkOutput("max_last_data", wrData[1023], 32'h3FF);
    end
    checkOutput("max_we_pulse", 32'(weStuck), 32'd0);
    @(negedge CLK);

    // Timeout: partial word then silence
    clearLog();
    applyStimulus(8'hA5); applyStimulus(8'h01); applyStimulus(8'h00);
    applyStimulus(8'h13); applyStimulus(8'h00);
    endFrame();
    repeat (TIMEOUT_CLKS - 1) @(negedge CLK);
    checkOutput("tmo_early", 32'(Err_out), 32'd0);
    @(negedge CLK);
    checkOutput("tmo_err",  32'(Err_out), 32'd1);
    checkOutput("tmo_code", 32'(Err_Code_out), 32'd3);
    checkOutput("tmo_hold", 32'(CPU_Hold_out), 32'd1);
    repeat (2) @(negedge CLK);
    applyStimulus(8'h00); applyStimulus(8'hFF);
    endFrame();
    repeat (3) @(negedge CLK);
    checkOutput("noise_err",  32'(Err_out), 32'd1);
    checkOutput("noise_code", 32'(Err_Code_out), 32'd3);
    checkOutput("tmo_wrcount", 32'(wrAddr.size()), 32'd0);

    // Zero length, back-to-back, with leading junk
    clearLog();
    applyStimulus(8'h12); applyStimulus(8'h34);
    applyStimulus(8'hA5); applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h00);
    endFrame();
    checkOutput("zero_done", 32'(Load_Done_out), 32'd1);
    checkOutput("zero_err",  32'(Err_out), 32'd0);
    checkOutput("zero_hold", 32'(CPU_Hold_out), 32'd0);
    checkOutput("zero_wrcount", 32'(wrAddr.size()), 32'd0);
    @(negedge CLK);

    // Reset during the third data byte
    clearLog();
    applyStimulus(8'hA5); applyStimulus(8'h01); applyStimulus(8'h00);
    applyStimulus(8'h13); applyStimulus(8'h00);
    @(negedge CLK);
    Rx_DV_in   = 1'b1;
    Rx_Byte_in = 8'h00;
    #1;
    checkOutput("mid_hold_pre", 32'(CPU_Hold_out), 32'd1);
    #1 RST = 1'b1;
    #1;
    checkOutput("mid_rst_hold", 32'(CPU_Hold_out), 32'd0);
    checkOutput("mid_rst_addr", 32'(Mem_Addr_out), 32'd0);
    checkOutput("mid_rst_data", Mem_Data_out, 32'd0);
    checkOutput("mid_rst_we",   32'(Mem_WE_out), 32'd0);
    @(negedge CLK);
    Rx_DV_in = 1'b0;
    RST      = 1'b0;
    repeat (2) @(negedge CLK);
    checkOutput("mid_wrcount", 32'(wrAddr.size()), 32'd0);

    // Normal load after reset release
    clearLog();
    sendGoodFrame(8'h90);
    checkOutput("post_done", 32'(Load_Done_out), 32'd1);
    checkTwoWrites("post");
    repeat (2) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Sits directly downstream of the UART receiver. Consumes its byte-valid pulse and byte, parses a framed program image, and emits 32-bit word writes into the Custom_CPU instruction memory.
- Holds the CPU in reset while a load is in progress.
- Reports a done pulse or an error code per frame.
- Frame format, in order:
  - 0xA5 sync byte
  - word count N, 16-bit little-endian (2 bytes)
  - N words, each 4 bytes, little-endian
  - 1 checksum byte: XOR of all word bytes

Parameters:
ADDR_WIDTH, 10, instruction-memory word-address width; maximum N is 2^ADDR_WIDTH.
TIMEOUT_CLKS, 217000, idle clocks allowed between bytes inside a frame (about 100 byte times at 115200 baud, 25 MHz).

Ports:
CLK  input  1  system clock, 25 MHz
RST  input  1  asynchronous, active-high reset
Rx_DV_in  input  1  byte-valid pulse from the UART receiver, one cycle wide
Rx_Byte_in  input  8  received byte, valid while Rx_DV_in=1
Mem_WE_out  output  1  instruction-memory write enable, one-cycle pulse
Mem_Addr_out  output  ADDR_WIDTH  word address of the write
Mem_Data_out  output  32  write data
CPU_Hold_out  output  1  holds the CPU in reset while high
Load_Done_out  output  1  one-cycle pulse on a good frame
Err_out  output  1  sticky error flag
Err_Code_out  output  2  error cause: 00 none, 01 checksum, 10 length, 11 timeout

Behaviour:
- Reset:
  - RST is asynchronous and active-high; it applies immediately, including mid-frame.
  - All outputs go to 0, state goes to S_IDLE, and the counters, checksum and word registers clear.
- Byte acceptance: a byte is consumed only on a cycle with Rx_DV_in=1. There is no backpressure. Back-to-back DV cycles must be accepted.
- States:
  - S_IDLE: bytes other than 0xA5 are ignored. On 0xA5: go to S_LEN_LO, set CPU_Hold_out=1, clear Err_out/Err_Code_out, clear checksum, word index and byte index.
  - S_LEN_LO: capture N[7:0], go to S_LEN_HI.
  - S_LEN_HI: capture N[15:8], then branch on N:
    - N > 2^ADDR_WIDTH: go to S_ERROR with code 10.
    - N == 0: go to S_CHECK (expected checksum is 0x00).
    - Otherwise: go to S_DATA.
  - S_DATA:
    - Each byte is placed at word[8*byte_idx +: 8] and XORed into the checksum.
    - On the 4th byte's DV edge, register Mem_WE_out=1, Mem_Addr_out=word_idx and Mem_Data_out=assembled word. The write is visible the cycle after DV, and Mem_WE_out returns to 0 on the next cycle.
    - Mem_Addr_out and Mem_Data_out hold their last values between writes.
    - word_idx increments after each write. When word_idx reaches N, go to S_CHECK.
  - S_CHECK: compare the next byte with the checksum.
    - Equal: go to S_DONE.
    - Not equal: go to S_ERROR with code 01.
  - S_DONE: one cycle. Load_Done_out=1 for exactly this cycle, CPU_Hold_out goes to 0 on the same edge, then go to S_IDLE.
  - S_ERROR: one cycle. Err_out=1, Err_Code_out is latched, CPU_Hold_out stays 1, then go to S_IDLE.
- Timeout:
  - A counter runs in every state except S_IDLE and S_IDLE-bound transients.
  - It reloads to 0 on each Rx_DV_in.
  - When it reaches TIMEOUT_CLKS-1: go to S_ERROR with code 11, and discard the partial word (no write).
- Error persistence:
  - Err_out and Err_Code_out hold until the next accepted 0xA5 or RST.
  - CPU_Hold_out stays 1 after any error until a later frame completes successfully or RST.
- Widths:
  - word_idx and N compare as 17-bit unsigned values, so N = 2^ADDR_WIDTH is legal.
  - Mem_Addr_out takes word_idx[ADDR_WIDTH-1:0].
- Sync byte inside a frame: 0xA5 is treated as ordinary data; no resync.
- Simultaneous events:
  - If Rx_DV_in and timeout expiry land on the same cycle, the byte wins and the counter reloads.
  - If Rx_DV_in arrives in the S_DONE or S_ERROR cycle, it is dropped.

Test Plan:
- Good frame: send A5 02 00 13 00 00 00 93 00 10 00 90.
  - Mem_WE_out pulses twice: addr 0 / data 0x00000013, then addr 1 / data 0x00100093.
  - Load_Done_out is a single pulse one cycle after the 0x90 DV.
  - CPU_Hold_out is 1 from the A5 edge until Done, then 0; Err_out=0.
- Bad checksum: same frame ending in 0x91.
  - Both writes still occur.
  - Err_out=1, Err_Code_out=01, no Done, CPU_Hold_out remains 1.
  - A following good frame clears Err_out at its A5 and ends with Done.
- Length limit (ADDR_WIDTH=10):
  - A5 01 04 (N=0x0401) gives Err_Code_out=10 immediately, with no writes.
  - A5 00 04 (N=1024) is accepted, and its last write goes to addr 0x3FF.
- Timeout (TIMEOUT_CLKS=1000): send A5 01 00 13 00, then go silent.
  - Err_Code_out=11 exactly 1000 cycles after the last DV, with no write.
  - Noise bytes (e.g. 0x00, 0xFF) sent after return to S_IDLE are ignored.
- Zero length and back-to-back: A5 00 00 00 with Rx_DV_in asserted on consecutive cycles.
  - Done pulse, no writes.
  - Junk bytes 0x12 0x34 before the A5 are ignored.
- Reset mid-frame: assert RST during the 3rd data byte.
  - All outputs go to 0 asynchronously, with no write.
  - After release, a good frame loads normally from addr 0.
